sdo_frame_rx: RTL and testbench

//   Receiving end of the SDO serial stream produced by the apex7 control block.

---
 rtl/sdo_frame_rx.sv | 161 ++++++++++++++++
 tb/tb_sdo_frame_rx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdo_frame_rx.sv
// sdo_frame_rx: receiver for the framed SDO serial stream.
// A frame is start(1), DATA_W data bits (LSB first), even parity and stop(0).
// Accepted frames give a one-cycle RX_VALID pulse. Stop-bit faults and watchdog
// aborts give a one-cycle FRM_ERR pulse. All outputs are registered.
`timescale 1ns/1ps
module sdo_frame_rx #(
   parameter int unsigned DATA_W  = 6,
   parameter int unsigned TIMEOUT = 127,
   parameter int unsigned CNT_W   = 8
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              CLR,
   input  logic              SHIFT_EN,
   input  logic              SDI,
   output logic [DATA_W-1:0] RX_DATA,
   output logic              RX_VALID,
   output logic              PAR_ERR,
   output logic              FRM_ERR,
   output logic              BUSY,
   output logic [CNT_W-1:0]  FRAME_CNT
);

   localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   // The watchdog only has to hold 0..TIMEOUT-1; reaching TIMEOUT is the abort itself.
   localparam int unsigned WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   state_t             state, state_nxt;
   logic [DATA_W-1:0]  shreg, shreg_nxt;
   logic [IDX_W-1:0]   idx, idx_nxt;
   logic               par_acc, par_acc_nxt;
   logic               par_bad, par_bad_nxt;
   logic [WD_W-1:0]    wdog, wdog_nxt;
   logic [DATA_W-1:0]  data_nxt;
   logic               valid_nxt, perr_nxt, ferr_nxt, busy_nxt;
   logic [CNT_W-1:0]   cnt_nxt;

   // State register; CLR acts like reset and drops any partial frame silently.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= S_IDLE;
      end else if (CLR) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         shreg     <= '0;
         idx       <= '0;
         par_acc   <= 1'b0;
         par_bad   <= 1'b0;
         wdog      <= '0;
         RX_DATA   <= '0;
         RX_VALID  <= 1'b0;
         PAR_ERR   <= 1'b0;
         FRM_ERR   <= 1'b0;
         BUSY      <= 1'b0;
         FRAME_CNT <= '0;
      end else if (CLR) begin
         shreg     <= '0;
         idx       <= '0;
         par_acc   <= 1'b0;
         par_bad   <= 1'b0;
         wdog      <= '0;
         RX_DATA   <= '0;
         RX_VALID  <= 1'b0;
         PAR_ERR   <= 1'b0;
         FRM_ERR   <= 1'b0;
         BUSY      <= 1'b0;
         FRAME_CNT <= '0;
      end else begin
         shreg     <= shreg_nxt;
         idx       <= idx_nxt;
         par_acc   <= par_acc_nxt;
         par_bad   <= par_bad_nxt;
         wdog      <= wdog_nxt;
         RX_DATA   <= data_nxt;
         RX_VALID  <= valid_nxt;
         PAR_ERR   <= perr_nxt;
         FRM_ERR   <= ferr_nxt;
         BUSY      <= busy_nxt;
         FRAME_CNT <= cnt_nxt;
      end
   end

   // Next-state and next-output logic. A strobe always beats the watchdog.
   always_comb begin
      state_nxt   = state;
      shreg_nxt   = shreg;
      idx_nxt     = idx;
      par_acc_nxt = par_acc;
      par_bad_nxt = par_bad;
      wdog_nxt    = wdog;
      data_nxt    = RX_DATA;
      valid_nxt   = 1'b0;
      perr_nxt    = 1'b0;
      ferr_nxt    = 1'b0;
      cnt_nxt     = FRAME_CNT;

      if (SHIFT_EN) begin
         wdog_nxt = '0;
         unique case (state)
            S_IDLE: begin
               if (SDI) begin
                  state_nxt   = S_DATA;
                  idx_nxt     = '0;
                  par_acc_nxt = 1'b0;
               end
            end
            S_DATA: begin
               shreg_nxt[idx] = SDI;
               par_acc_nxt    = par_acc ^ SDI;
               if (idx == IDX_LAST) begin
                  state_nxt = S_PARITY;
               end else begin
                  idx_nxt = idx + 1'b1;
               end
            end
            S_PARITY: begin
               par_bad_nxt = par_acc ^ SDI;
               state_nxt   = S_STOP;
            end
            S_STOP: begin
               if (!SDI) begin
                  data_nxt  = shreg;
                  valid_nxt = 1'b1;
                  perr_nxt  = par_bad;
                  if (FRAME_CNT != '1) begin
                     cnt_nxt = FRAME_CNT + 1'b1;
                  end
               end else begin
                  ferr_nxt = 1'b1;
               end
               state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
         endcase
      end else if (state != S_IDLE && TIMEOUT != 0) begin
         if (wdog == WD_LAST) begin
            state_nxt = S_IDLE;
            ferr_nxt  = 1'b1;
         end else begin
            wdog_nxt = wdog + 1'b1;
         end
      end

      if (state_nxt == S_IDLE) begin
         wdog_nxt = '0;
      end
      busy_nxt = (state_nxt != S_IDLE);
   end

endmodule

// File: tb/tb_sdo_frame_rx.sv
// Scoreboard bench for sdo_frame_rx: the driver pushes the expected outcome of
// every frame (edge, flags, data, count) and a negedge monitor pops on each pulse.
`timescale 1ns/1ps
module tb_sdo_frame_rx;

   localparam int unsigned DW = 6;
   localparam int unsigned TO = 127;
   localparam int unsigned CW = 8;

   logic          CLK = 1'b0;
   logic          RST_N, CLR, SHIFT_EN, SDI;
   logic [DW-1:0] RX_DATA;
   logic          RX_VALID, PAR_ERR, FRM_ERR, BUSY;
   logic [CW-1:0] FRAME_CNT;

   sdo_frame_rx #(.DATA_W(DW), .TIMEOUT(TO), .CNT_W(CW)) dut (
      .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .SHIFT_EN(SHIFT_EN), .SDI(SDI),
      .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .PAR_ERR(PAR_ERR),
      .FRM_ERR(FRM_ERR), .BUSY(BUSY), .FRAME_CNT(FRAME_CNT)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int            at;
      logic          v;
      logic          p;
      logic          f;
      logic [DW-1:0] d;
      logic [CW-1:0] c;
   } exp_t;

   exp_t          q[$];
   int            edge_cnt = 0;
   int            last_edge = 0;
   int            total = 0;
   int            bad = 0;
   logic [DW-1:0] mdata = '0;
   int            mcnt = 0;

   always @(posedge CLK) edge_cnt <= edge_cnt + 1;

   // Monitor: any pulse must match the oldest expected event at the right edge.
   always @(negedge CLK) begin
      exp_t e;
      while (q.size() > 0 && q[0].at < edge_cnt) begin
         e = q.pop_front();
         total++;
         bad++;
         $display("FAIL missing_event: no pulse seen, required at edge %0d (v=%0b f=%0b)", e.at, e.v, e.f);
      end
      if (RX_VALID || FRM_ERR || PAR_ERR) begin
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_pulse: edge %0d v=%0b p=%0b f=%0b, required none",
                     edge_cnt, RX_VALID, PAR_ERR, FRM_ERR);
         end else begin
            e = q.pop_front();
            if (edge_cnt != e.at || RX_VALID !== e.v || PAR_ERR !== e.p || FRM_ERR !== e.f ||
                RX_DATA !== e.d || FRAME_CNT !== e.c) begin
               bad++;
               $display("FAIL frame_result: got edge=%0d v=%0b p=%0b f=%0b d=%h c=%0d, required edge=%0d v=%0b p=%0b f=%0b d=%h c=%0d",
                        edge_cnt, RX_VALID, PAR_ERR, FRM_ERR, RX_DATA, FRAME_CNT,
                        e.at, e.v, e.p, e.f, e.d, e.c);
            end
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", nm, act, req);
      end
   endtask

   // One clock of stimulus, applied at the falling edge and sampled at the next rising edge.
   task automatic step(input logic en, input logic d);
      @(negedge CLK);
      SHIFT_EN  = en;
      SDI       = d;
      CLR       = 1'b0;
      last_edge = edge_cnt + 1;
   endtask

   // Reference model: outcome of a complete frame, from the framing rules alone.
   function automatic void expect_frame(input logic [DW-1:0] d, input logic pb, input logic sb, input int at);
      exp_t e;
      e.at = at;
      if (!sb) begin
         if (mcnt < (1 << CW) - 1) mcnt++;
         mdata = d;
         e.v = 1'b1;
         e.p = (^d) ^ pb;
         e.f = 1'b0;
      end else begin
         e.v = 1'b0;
         e.p = 1'b0;
         e.f = 1'b1;
      end
      e.d = mdata;
      e.c = CW'(mcnt);
      q.push_back(e);
   endfunction

   // Sends a frame; optionally stalls (SHIFT_EN low) before strobe number stall_after.
   // A stall of TO cycles or more ends the frame with a watchdog abort.
   task automatic send_frame(input logic [DW-1:0] d, input logic pb, input logic sb,
                             input int stall_after, input int stall_len);
      logic [DW+2:0] bits;
      exp_t e;
      bits = {sb, pb, d, 1'b1};
      for (int i = 0; i < DW + 3; i++) begin
         if (i == stall_after && stall_len > 0) begin
            if (stall_len >= TO) begin
               for (int k = 0; k < TO; k++) step(1'b0, 1'($urandom));
               e.at = last_edge;
               e.v  = 1'b0;
               e.p  = 1'b0;
               e.f  = 1'b1;
               e.d  = mdata;
               e.c  = CW'(mcnt);
               q.push_back(e);
               return;
            end
            for (int k = 0; k < stall_len; k++) step(1'b0, 1'($urandom));
         end
         step(1'b1, bits[i]);
      end
      expect_frame(d, pb, sb, last_edge);
   endtask

   initial begin
      logic [DW-1:0] rd;
      logic          rpb, rsb;
      int            sa, sl;

      RST_N = 1'b0; CLR = 1'b0; SHIFT_EN = 1'b0; SDI = 1'b0;
      repeat (2) @(negedge CLK);
      check("reset_rx_data",   32'(RX_DATA),   0);
      check("reset_rx_valid",  32'(RX_VALID),  0);
      check("reset_par_err",   32'(PAR_ERR),   0);
      check("reset_frm_err",   32'(FRM_ERR),   0);
      check("reset_busy",      32'(BUSY),      0);
      check("reset_frame_cnt", 32'(FRAME_CNT), 0);
      RST_N = 1'b1;
      step(1'b1, 1'b0);

      // Directed frames.
      send_frame(6'h2D, 1'b0, 1'b0, -1, 0);
      send_frame(6'h2D, 1'b1, 1'b0, -1, 0);
      send_frame(6'h15, 1'b1, 1'b1, -1, 0);
      step(1'b0, 1'b0);

      // Watchdog abort after start + 2 data bits.
      send_frame(6'h21, 1'b0, 1'b0, 3, TO);
      check("busy_before_abort", 32'(BUSY), 1);
      @(negedge CLK);
      check("busy_after_abort", 32'(BUSY), 0);
      check("data_held_abort", 32'(RX_DATA), 32'h2D);

      // Strobe arrives on the last tolerated cycle: frame must complete.
      send_frame(6'h0A, 1'b0, 1'b0, 3, TO - 1);
      send_frame(6'h3F, 1'b0, 1'b0, -1, 0);

      // CLR mid-frame after 3 data bits.
      step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
      @(negedge CLK);
      SHIFT_EN = 1'b0; CLR = 1'b1;
      @(negedge CLK);
      CLR = 1'b0; mcnt = 0; mdata = '0;
      check("clr_rx_data",   32'(RX_DATA),   0);
      check("clr_frame_cnt", 32'(FRAME_CNT), 0);
      check("clr_busy",      32'(BUSY),      0);
      send_frame(6'h01, 1'b1, 1'b0, -1, 0);

      // Asynchronous reset mid-frame after 3 data bits.
      step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1); step(1'b1, 1'b1);
      @(negedge CLK);
      SHIFT_EN = 1'b0; RST_N = 1'b0;
      #1;
      check("rst_rx_data",   32'(RX_DATA),   0);
      check("rst_frame_cnt", 32'(FRAME_CNT), 0);
      check("rst_busy",      32'(BUSY),      0);
      mcnt = 0; mdata = '0;
      @(negedge CLK);
      RST_N = 1'b1;
      send_frame(6'h01, 1'b1, 1'b0, -1, 0);

      // Randomized frames with stalls, gaps, parity and stop faults.
      for (int n = 0; n < 40; n++) begin
         rd  = DW'($urandom);
         rpb = (^rd) ^ ($urandom_range(0, 3) == 0);
         rsb = ($urandom_range(0, 5) == 0);
         sa  = -1;
         sl  = 0;
         if ($urandom_range(0, 3) == 0) begin
            sa = $urandom_range(1, DW + 2);
            sl = ($urandom_range(0, 9) == 0) ? TO + $urandom_range(0, 5) : $urandom_range(1, 20);
         end
         send_frame(rd, rpb, rsb, sa, sl);
         for (int g = $urandom_range(0, 3); g > 0; g--) step(1'($urandom), 1'b0);
      end

      // Back-to-back good frames, SHIFT_EN high throughout; counter saturates.
      for (int n = 0; n < 260; n++) begin
         rd = DW'($urandom);
         send_frame(rd, ^rd, 1'b0, -1, 0);
      end
      step(1'b0, 1'b0);
      repeat (3) @(negedge CLK);
      check("frame_cnt_saturated", 32'(FRAME_CNT), 32'hFF);
      check("scoreboard_drained", 32'(q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
